// File: rtl/raster_pkg.sv
// Shared types and constants for the raster region scanner.
package raster_pkg;

  // Run sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scanState_t;

  // Default visible frame size (VGA adapter at 160x120)
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  // Colour driven while clearing a region
  localparam logic [2:0] COL_BLACK = 3'b000;

endpackage

// File: rtl/pix_delay_line.sv
// Stallable delay line that keeps pixel coordinates/valid aligned with ROM data.
module pix_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  generate
    if (DEPTH == 0) begin : gPass
      // Combinational ROM: no alignment needed
      assign dout = din;
    end else begin : gPipe
      logic [DEPTH-1:0][DW-1:0] stage;

      // Shift one stage per enabled cycle; reset drops all in-flight pixels
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage <= '0;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/raster_region_scanner.sv
// Sweeps a rectangular screen region row-major, addressing a sprite ROM and
// driving x/y/colour/plot to the VGA adapter with ROM-latency alignment.
module raster_region_scanner
  import raster_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = 15,
  parameter int COL_W    = 3,
  parameter int ROM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clearMode,
  input  logic              hold,
  input  logic [X_W-1:0]    xOrigin,
  input  logic [Y_W-1:0]    yOrigin,
  input  logic [X_W:0]      width,
  input  logic [Y_W:0]      height,
  input  logic [COL_W-1:0]  colorIn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [COL_W-1:0]  color,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam int PW = 1 + (X_W + 1) + (Y_W + 1);
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);
  localparam logic [1:0]   DRAIN_LAST = 2'(ROM_LAT - 1);

  scanState_t     state;
  logic [X_W-1:0] xOrgR;
  logic [Y_W-1:0] yOrgR;
  logic [X_W:0]   widthR, col;
  logic [Y_W:0]   heightR, row;
  logic           clrR;
  logic [1:0]     drainCnt;

  logic           lastCol, lastRow;
  logic [X_W:0]   absX;
  logic [Y_W:0]   absY;
  logic [PW-1:0]  pipeIn, pipeOut;
  logic           outValid;
  logic [X_W:0]   outX;
  logic [Y_W:0]   outY;

  assign lastCol = (col == widthR - 1'b1);
  assign lastRow = (row == heightR - 1'b1);

  // Absolute coordinates carry one extra bit so off-screen pixels never wrap
  assign absX   = {1'b0, xOrgR} + col;
  assign absY   = {1'b0, yOrgR} + row;
  assign pipeIn = {(state == RUN), absX, absY};

  // Scan sequencer: counters, linear address and run state; hold freezes all
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      xOrgR    <= '0;
      yOrgR    <= '0;
      widthR   <= '0;
      heightR  <= '0;
      clrR     <= 1'b0;
      col      <= '0;
      row      <= '0;
      memAddr  <= '0;
      drainCnt <= '0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (start) begin
            xOrgR   <= xOrigin;
            yOrgR   <= yOrigin;
            widthR  <= width;
            heightR <= height;
            clrR    <= clearMode;
            col     <= '0;
            row     <= '0;
            memAddr <= '0;
            state   <= (width == '0 || height == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (lastCol) begin
            if (lastRow) begin
              // Counters stop on the final pixel so memAddr tops out at W*H-1
              drainCnt <= '0;
              state    <= (ROM_LAT == 0) ? DONE : DRAIN;
            end else begin
              col     <= '0;
              row     <= row + 1'b1;
              memAddr <= memAddr + 1'b1;
            end
          end else begin
            col     <= col + 1'b1;
            memAddr <= memAddr + 1'b1;
          end
        end
        DRAIN: begin
          if (drainCnt == DRAIN_LAST) state <= DONE;
          else                        drainCnt <= drainCnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pix_delay_line #(
    .DEPTH (ROM_LAT),
    .DW    (PW)
  ) uDelay (
    .clk   (clk),
    .reset (reset),
    .en    (!hold),
    .din   (pipeIn),
    .dout  (pipeOut)
  );

  assign {outValid, outX, outY} = pipeOut;

  // Output stage: clip against the visible frame, suppress writes while held
  assign plot  = outValid & ~hold & (outX < SCR_W) & (outY < SCR_H);
  assign x     = outX[X_W-1:0];
  assign y     = outY[Y_W-1:0];
  assign color = (outValid && !clrR) ? colorIn : COL_W'(COL_BLACK);
  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);

endmodule
